reglk_access_ctrl: RTL and testbench



---
 rtl/reglk_pkg.sv | 26 ++
 rtl/reglk_rr_arb.sv | 34 +++
 rtl/reglk_access_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_reglk_access_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reglk_pkg.sv
// Shared types and constants for the register-lock access controller.
package reglk_pkg;

   localparam int DEF_NB_WORDS   = 6;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 8;
   localparam int IDX_WIDTH      = 5;

   typedef enum logic [1:0] {
      INIT,
      ARB,
      ISSUE,
      RESP
   } state_e;

   typedef enum logic {
      OWN_CPU,
      OWN_DBG
   } owner_e;

   // Lock words are 8 bytes apart, so the word index is the byte address above bit 2.
   function automatic logic [IDX_WIDTH-1:0] word_idx(input logic [DEF_ADDR_WIDTH-1:0] addr);
      return addr[7:3];
   endfunction

endpackage

// File: rtl/reglk_rr_arb.sv
// Two-way round-robin arbiter; bit 0 is the CPU, bit 1 is the debug requester.
module reglk_rr_arb (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req_i,
   input  logic       advance_i,
   output logic [1:0] gnt_o
);

   logic ptr_q;
   logic ptr_d;

   // Pick the winner and, on advance, point the priority at the loser.
   always_comb begin
      gnt_o = req_i;
      if (req_i == 2'b11) begin
         gnt_o = ptr_q ? 2'b10 : 2'b01;
      end
      ptr_d = ptr_q;
      if (advance_i && (gnt_o != 2'b00)) begin
         ptr_d = gnt_o[0];
      end
   end

   // Priority pointer starts at the CPU.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/reglk_access_ctrl.sv
// Register-lock access controller: boot programming, CPU/debug arbitration and sticky lockdown.
module reglk_access_ctrl
   import reglk_pkg::*;
#(
   parameter int NB_WORDS   = DEF_NB_WORDS,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [NB_WORDS*DATA_WIDTH-1:0] init_val_i,
   input  logic                           cpu_req_i,
   input  logic                           cpu_we_i,
   input  logic [ADDR_WIDTH-1:0]          cpu_addr_i,
   input  logic [DATA_WIDTH-1:0]          cpu_wdata_i,
   output logic                           cpu_gnt_o,
   output logic                           cpu_rvalid_o,
   output logic [DATA_WIDTH-1:0]          cpu_rdata_o,
   output logic                           cpu_err_o,
   input  logic                           dbg_req_i,
   input  logic                           dbg_we_i,
   input  logic [ADDR_WIDTH-1:0]          dbg_addr_i,
   input  logic [DATA_WIDTH-1:0]          dbg_wdata_i,
   output logic                           dbg_gnt_o,
   output logic                           dbg_rvalid_o,
   output logic [DATA_WIDTH-1:0]          dbg_rdata_o,
   output logic                           dbg_err_o,
   input  logic                           jtag_unlock_i,
   input  logic                           lockdown_i,
   output logic                           reg_en_o,
   output logic                           reg_we_o,
   output logic [ADDR_WIDTH-1:0]          reg_addr_o,
   output logic [DATA_WIDTH-1:0]          reg_wdata_o,
   input  logic [DATA_WIDTH-1:0]          reg_rdata_i,
   output logic                           init_done_o,
   output logic                           locked_o
);

   state_e                 state_q, state_d;
   owner_e                 owner_q, owner_d;
   logic [IDX_WIDTH-1:0]   init_cnt_q, init_cnt_d;
   logic                   init_done_q, init_done_d;
   logic                   locked_q, locked_d;
   logic                   we_lat_q, we_lat_d;
   logic [ADDR_WIDTH-1:0]  addr_lat_q, addr_lat_d;
   logic [DATA_WIDTH-1:0]  wdata_lat_q, wdata_lat_d;
   logic                   acc_valid_q, acc_valid_d;
   logic                   cpu_gnt_q, cpu_gnt_d, dbg_gnt_q, dbg_gnt_d;
   logic                   cpu_rvalid_q, cpu_rvalid_d, dbg_rvalid_q, dbg_rvalid_d;
   logic [DATA_WIDTH-1:0]  cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
   logic                   cpu_err_q, cpu_err_d, dbg_err_q, dbg_err_d;
   logic                   reg_en_q, reg_en_d, reg_we_q, reg_we_d;
   logic [ADDR_WIDTH-1:0]  reg_addr_q, reg_addr_d;
   logic [DATA_WIDTH-1:0]  reg_wdata_q, reg_wdata_d;
   logic [1:0]             arb_req;
   logic [1:0]             arb_gnt;
   logic                   arb_adv;
   logic                   access_ok;
   logic [DATA_WIDTH-1:0]  resp_data;
   logic                   resp_err;

   assign arb_req = {dbg_req_i & jtag_unlock_i, cpu_req_i};

   reglk_rr_arb u_arb (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_i     (arb_req),
      .advance_i (arb_adv),
      .gnt_o     (arb_gnt)
   );

   // Next-state logic for the sequencer; every output is computed here and registered below.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      init_cnt_d   = init_cnt_q;
      init_done_d  = init_done_q | (state_q != INIT);
      locked_d     = locked_q | lockdown_i;
      we_lat_d     = we_lat_q;
      addr_lat_d   = addr_lat_q;
      wdata_lat_d  = wdata_lat_q;
      acc_valid_d  = acc_valid_q;
      cpu_gnt_d    = 1'b0;
      dbg_gnt_d    = 1'b0;
      cpu_rvalid_d = 1'b0;
      dbg_rvalid_d = 1'b0;
      cpu_rdata_d  = '0;
      dbg_rdata_d  = '0;
      cpu_err_d    = 1'b0;
      dbg_err_d    = 1'b0;
      reg_en_d     = 1'b0;
      reg_we_d     = 1'b0;
      reg_addr_d   = '0;
      reg_wdata_d  = '0;
      arb_adv      = 1'b0;
      access_ok    = 1'b0;
      resp_data    = '0;
      resp_err     = 1'b0;

      case (state_q)
         INIT: begin
            reg_en_d    = 1'b1;
            reg_we_d    = 1'b1;
            reg_addr_d  = ADDR_WIDTH'({init_cnt_q, 3'b000});
            reg_wdata_d = init_val_i[init_cnt_q*DATA_WIDTH +: DATA_WIDTH];
            if (init_cnt_q == IDX_WIDTH'(NB_WORDS - 1)) begin
               state_d = ARB;
            end else begin
               init_cnt_d = init_cnt_q + 1'b1;
            end
         end
         ARB: begin
            arb_adv = 1'b1;
            if (arb_gnt[0]) begin
               cpu_gnt_d   = 1'b1;
               owner_d     = OWN_CPU;
               we_lat_d    = cpu_we_i;
               addr_lat_d  = cpu_addr_i;
               wdata_lat_d = cpu_wdata_i;
               state_d     = ISSUE;
            end else if (arb_gnt[1]) begin
               dbg_gnt_d   = 1'b1;
               owner_d     = OWN_DBG;
               we_lat_d    = dbg_we_i;
               addr_lat_d  = dbg_addr_i;
               wdata_lat_d = dbg_wdata_i;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            // A lockdown arriving in the grant cycle already blocks this write.
            access_ok = (word_idx(addr_lat_q) < IDX_WIDTH'(NB_WORDS)) && !(we_lat_q && locked_d);
            acc_valid_d = access_ok;
            if (access_ok) begin
               reg_en_d    = 1'b1;
               reg_we_d    = we_lat_q;
               reg_addr_d  = addr_lat_q;
               reg_wdata_d = wdata_lat_q;
            end
            state_d = RESP;
         end
         RESP: begin
            resp_data = (acc_valid_q && !we_lat_q) ? reg_rdata_i : '0;
            resp_err  = !acc_valid_q;
            if (owner_q == OWN_CPU) begin
               cpu_rvalid_d = 1'b1;
               cpu_rdata_d  = resp_data;
               cpu_err_d    = resp_err;
            end else begin
               dbg_rvalid_d = 1'b1;
               dbg_rdata_d  = resp_data;
               dbg_err_d    = resp_err;
            end
            state_d = ARB;
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   // State, latches and registered outputs; reset restarts boot programming.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= INIT;
         owner_q      <= OWN_CPU;
         init_cnt_q   <= '0;
         init_done_q  <= 1'b0;
         locked_q     <= 1'b0;
         we_lat_q     <= 1'b0;
         addr_lat_q   <= '0;
         wdata_lat_q  <= '0;
         acc_valid_q  <= 1'b0;
         cpu_gnt_q    <= 1'b0;
         dbg_gnt_q    <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         dbg_rvalid_q <= 1'b0;
         cpu_rdata_q  <= '0;
         dbg_rdata_q  <= '0;
         cpu_err_q    <= 1'b0;
         dbg_err_q    <= 1'b0;
         reg_en_q     <= 1'b0;
         reg_we_q     <= 1'b0;
         reg_addr_q   <= '0;
         reg_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         init_cnt_q   <= init_cnt_d;
         init_done_q  <= init_done_d;
         locked_q     <= locked_d;
         we_lat_q     <= we_lat_d;
         addr_lat_q   <= addr_lat_d;
         wdata_lat_q  <= wdata_lat_d;
         acc_valid_q  <= acc_valid_d;
         cpu_gnt_q    <= cpu_gnt_d;
         dbg_gnt_q    <= dbg_gnt_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         dbg_rvalid_q <= dbg_rvalid_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dbg_rdata_q  <= dbg_rdata_d;
         cpu_err_q    <= cpu_err_d;
         dbg_err_q    <= dbg_err_d;
         reg_en_q     <= reg_en_d;
         reg_we_q     <= reg_we_d;
         reg_addr_q   <= reg_addr_d;
         reg_wdata_q  <= reg_wdata_d;
      end
   end

   assign cpu_gnt_o    = cpu_gnt_q;
   assign dbg_gnt_o    = dbg_gnt_q;
   assign cpu_rvalid_o = cpu_rvalid_q;
   assign dbg_rvalid_o = dbg_rvalid_q;
   assign cpu_rdata_o  = cpu_rdata_q;
   assign dbg_rdata_o  = dbg_rdata_q;
   assign cpu_err_o    = cpu_err_q;
   assign dbg_err_o    = dbg_err_q;
   assign reg_en_o     = reg_en_q;
   assign reg_we_o     = reg_we_q;
   assign reg_addr_o   = reg_addr_q;
   assign reg_wdata_o  = reg_wdata_q;
   assign init_done_o  = init_done_q;
   assign locked_o     = locked_q;

endmodule

// File: tb/tb_reglk_access_ctrl.sv
// Directed bench for reglk_access_ctrl with a behavioural lock-file model.
module tb_reglk_access_ctrl;

   logic         clk_i;
   logic         rst_ni;
   logic [191:0] init_val_i;
   logic         cpu_req_i, cpu_we_i;
   logic [7:0]   cpu_addr_i;
   logic [31:0]  cpu_wdata_i;
   logic         cpu_gnt_o, cpu_rvalid_o, cpu_err_o;
   logic [31:0]  cpu_rdata_o;
   logic         dbg_req_i, dbg_we_i;
   logic [7:0]   dbg_addr_i;
   logic [31:0]  dbg_wdata_i;
   logic         dbg_gnt_o, dbg_rvalid_o, dbg_err_o;
   logic [31:0]  dbg_rdata_o;
   logic         jtag_unlock_i, lockdown_i;
   logic         reg_en_o, reg_we_o;
   logic [7:0]   reg_addr_o;
   logic [31:0]  reg_wdata_o;
   logic [31:0]  reg_rdata_i;
   logic         init_done_o, locked_o;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      string       name;
      bit          dbg;
      bit          we;
      logic [7:0]  addr;
      logic [31:0] wdata;
      bit          lockPulse;
      bit          expEn;
      logic [31:0] expRdata;
      bit          expErr;
      bit          expLocked;
   } vec_t;

   vec_t vecs[12];

   logic        obsGnt, obsEn, obsWe, obsRvalid, obsErr, obsLocked;
   logic [7:0]  obsAddr;
   logic [31:0] obsRdata;

   reglk_access_ctrl dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .init_val_i   (init_val_i),
      .cpu_req_i    (cpu_req_i),
      .cpu_we_i     (cpu_we_i),
      .cpu_addr_i   (cpu_addr_i),
      .cpu_wdata_i  (cpu_wdata_i),
      .cpu_gnt_o    (cpu_gnt_o),
      .cpu_rvalid_o (cpu_rvalid_o),
      .cpu_rdata_o  (cpu_rdata_o),
      .cpu_err_o    (cpu_err_o),
      .dbg_req_i    (dbg_req_i),
      .dbg_we_i     (dbg_we_i),
      .dbg_addr_i   (dbg_addr_i),
      .dbg_wdata_i  (dbg_wdata_i),
      .dbg_gnt_o    (dbg_gnt_o),
      .dbg_rvalid_o (dbg_rvalid_o),
      .dbg_rdata_o  (dbg_rdata_o),
      .dbg_err_o    (dbg_err_o),
      .jtag_unlock_i(jtag_unlock_i),
      .lockdown_i   (lockdown_i),
      .reg_en_o     (reg_en_o),
      .reg_we_o     (reg_we_o),
      .reg_addr_o   (reg_addr_o),
      .reg_wdata_o  (reg_wdata_o),
      .reg_rdata_i  (reg_rdata_i),
      .init_done_o  (init_done_o),
      .locked_o     (locked_o)
   );

   // Free-running clock, period 10.
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Lock-file storage: synchronous write, combinational read.
   logic [31:0] mem [6];

   always @(posedge clk_i) begin
      if (reg_en_o && reg_we_o && (reg_addr_o[7:3] < 5'd6)) begin
         mem[reg_addr_o[7:3]] <= reg_wdata_o;
      end
   end

   always_comb begin
      reg_rdata_i = 32'h0;
      if (reg_addr_o[7:3] < 5'd6) begin
         reg_rdata_i = mem[reg_addr_o[7:3]];
      end
   end

   function automatic vec_t mkVec(string n, bit d, bit w, logic [7:0] a, logic [31:0] wd,
                                  bit lk, bit en, logic [31:0] rd, bit er, bit lo);
      vec_t v;
      v.name = n; v.dbg = d; v.we = w; v.addr = a; v.wdata = wd;
      v.lockPulse = lk; v.expEn = en; v.expRdata = rd; v.expErr = er; v.expLocked = lo;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Run one access on the chosen port and record what the DUT did at t, t+1 and t+2.
   task automatic applyStimulus(input vec_t v);
      int waitCnt;
      waitCnt = 0;
      obsGnt = 1'b0;
      if (v.dbg) begin
         dbg_req_i = 1'b1; dbg_we_i = v.we; dbg_addr_i = v.addr; dbg_wdata_i = v.wdata;
      end else begin
         cpu_req_i = 1'b1; cpu_we_i = v.we; cpu_addr_i = v.addr; cpu_wdata_i = v.wdata;
      end
      while (!obsGnt && waitCnt < 20) begin
         @(negedge clk_i);
         waitCnt++;
         obsGnt = v.dbg ? dbg_gnt_o : cpu_gnt_o;
      end
      if (v.lockPulse) lockdown_i = 1'b1;
      cpu_req_i = 1'b0;
      dbg_req_i = 1'b0;
      @(negedge clk_i);
      lockdown_i = 1'b0;
      obsEn   = reg_en_o;
      obsWe   = reg_we_o;
      obsAddr = reg_addr_o;
      @(negedge clk_i);
      obsRvalid = v.dbg ? dbg_rvalid_o : cpu_rvalid_o;
      obsRdata  = v.dbg ? dbg_rdata_o : cpu_rdata_o;
      obsErr    = v.dbg ? dbg_err_o : cpu_err_o;
      obsLocked = locked_o;
   endtask

   initial begin
      logic [1:0] gntPair;
      logic [1:0] expPair;
      int dbgGrants;
      int waitCnt;

      rst_ni = 1'b0;
      cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
      dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
      jtag_unlock_i = 1'b0;
      lockdown_i = 1'b0;
      for (int k = 0; k < 6; k++) init_val_i[k*32 +: 32] = 32'hA0 + k;

      vecs[0]  = mkVec("cpu_wr_10",     0, 1, 8'h10, 32'h1234, 0, 1, 32'h0,    0, 0);
      vecs[1]  = mkVec("cpu_rd_10",     0, 0, 8'h10, 32'h0,    0, 1, 32'h1234, 0, 0);
      vecs[2]  = mkVec("dbg_wr_20",     1, 1, 8'h20, 32'h5555, 0, 1, 32'h0,    0, 0);
      vecs[3]  = mkVec("dbg_rd_20",     1, 0, 8'h20, 32'h0,    0, 1, 32'h5555, 0, 0);
      vecs[4]  = mkVec("cpu_rd_30_oob", 0, 0, 8'h30, 32'h0,    0, 0, 32'h0,    1, 0);
      vecs[5]  = mkVec("dbg_rd_f8_oob", 1, 0, 8'hF8, 32'h0,    0, 0, 32'h0,    1, 0);
      vecs[6]  = mkVec("cpu_rd_28",     0, 0, 8'h28, 32'h0,    0, 1, 32'hA5,   0, 0);
      vecs[7]  = mkVec("cpu_wr_08_lock",0, 1, 8'h08, 32'hFFFF, 1, 0, 32'h0,    1, 1);
      vecs[8]  = mkVec("cpu_rd_08",     0, 0, 8'h08, 32'h0,    0, 1, 32'hA1,   0, 1);
      vecs[9]  = mkVec("dbg_wr_00_lock",1, 1, 8'h00, 32'hDEAD, 0, 0, 32'h0,    1, 1);
      vecs[10] = mkVec("dbg_rd_00",     1, 0, 8'h00, 32'h0,    0, 1, 32'hA0,   0, 1);
      vecs[11] = mkVec("cpu_wr_10_lock",0, 1, 8'h10, 32'h7777, 0, 0, 32'h0,    1, 1);

      // Reset state and boot programming, with a CPU read already waiting.
      repeat (2) @(negedge clk_i);
      checkOutput("rst_init_done", init_done_o, 0);
      checkOutput("rst_locked", locked_o, 0);
      checkOutput("rst_reg_en", reg_en_o, 0);
      checkOutput("rst_gnt", {cpu_gnt_o, dbg_gnt_o}, 0);
      cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 8'h18;
      rst_ni = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk_i);
         checkOutput($sformatf("init%0d_en_we", c), {reg_en_o, reg_we_o}, 2'b11);
         checkOutput($sformatf("init%0d_addr", c), reg_addr_o, (c - 1) * 8);
         checkOutput($sformatf("init%0d_wdata", c), reg_wdata_o, 32'hA0 + c - 1);
         checkOutput($sformatf("init%0d_gnt", c), cpu_gnt_o, 0);
         checkOutput($sformatf("init%0d_done", c), init_done_o, 0);
      end
      @(negedge clk_i);
      checkOutput("c7_init_done", init_done_o, 1);
      checkOutput("c7_cpu_gnt", cpu_gnt_o, 1);
      cpu_req_i = 1'b0;
      @(negedge clk_i);
      checkOutput("c8_reg_en_we", {reg_en_o, reg_we_o}, 2'b10);
      checkOutput("c8_reg_addr", reg_addr_o, 8'h18);
      @(negedge clk_i);
      checkOutput("c9_rvalid", cpu_rvalid_o, 1);
      checkOutput("c9_rdata", cpu_rdata_o, 32'hA3);
      checkOutput("c9_err", cpu_err_o, 0);

      // Single-access vectors on both ports, including lockdown and range errors.
      jtag_unlock_i = 1'b1;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i]);
         checkOutput({vecs[i].name, "_gnt"}, obsGnt, 1);
         checkOutput({vecs[i].name, "_reg_en"}, obsEn, vecs[i].expEn);
         if (vecs[i].expEn) begin
            checkOutput({vecs[i].name, "_reg_we"}, obsWe, vecs[i].we);
            checkOutput({vecs[i].name, "_reg_addr"}, obsAddr, vecs[i].addr);
         end
         checkOutput({vecs[i].name, "_rvalid"}, obsRvalid, 1);
         checkOutput({vecs[i].name, "_rdata"}, obsRdata, vecs[i].expRdata);
         checkOutput({vecs[i].name, "_err"}, obsErr, vecs[i].expErr);
         checkOutput({vecs[i].name, "_locked"}, obsLocked, vecs[i].expLocked);
      end

      // Debug requester is ignored while JTAG is not unlocked.
      jtag_unlock_i = 1'b0;
      dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 8'h00;
      dbgGrants = 0;
      repeat (12) begin
         @(negedge clk_i);
         if (dbg_gnt_o) dbgGrants++;
      end
      dbg_req_i = 1'b0;
      checkOutput("dbg_locked_out_grants", dbgGrants, 0);

      // Reset asserted during ISSUE aborts the access and clears the lock.
      jtag_unlock_i = 1'b1;
      cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 8'h10;
      waitCnt = 0;
      do begin
         @(negedge clk_i);
         waitCnt++;
      end while (!cpu_gnt_o && waitCnt < 20);
      checkOutput("abort_gnt", cpu_gnt_o, 1);
      rst_ni = 1'b0;
      cpu_req_i = 1'b0;
      repeat (2) begin
         @(negedge clk_i);
         checkOutput("abort_rvalid", cpu_rvalid_o, 0);
         checkOutput("abort_locked", locked_o, 0);
         checkOutput("abort_reg_en", reg_en_o, 0);
      end

      // Re-run INIT, then both requesters compete continuously.
      cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 8'h10;
      dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 8'h20;
      rst_ni = 1'b1;
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk_i);
         if (c <= 6) begin
            checkOutput($sformatf("reinit%0d_en", c), reg_en_o, 1);
            checkOutput($sformatf("reinit%0d_addr", c), reg_addr_o, (c - 1) * 8);
         end
         gntPair = {cpu_gnt_o, dbg_gnt_o};
         expPair = (c == 7 || c == 13) ? 2'b10 : (c == 10 || c == 16) ? 2'b01 : 2'b00;
         checkOutput($sformatf("rr_c%0d_gnt", c), gntPair, expPair);
         if (c == 9) begin
            checkOutput("rr_c9_cpu_rvalid", cpu_rvalid_o, 1);
            checkOutput("rr_c9_cpu_rdata", cpu_rdata_o, 32'hA2);
         end
         if (c == 12) begin
            checkOutput("rr_c12_dbg_rvalid", dbg_rvalid_o, 1);
            checkOutput("rr_c12_dbg_rdata", dbg_rdata_o, 32'hA4);
         end
      end
      cpu_req_i = 1'b0;
      dbg_req_i = 1'b0;
      repeat (3) @(negedge clk_i);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
